vx_issue_perf_ctr: RTL and testbench



---
 rtl/VX_gpu_pkg.sv | 19 +
 rtl/vx_perf_popcount_acc.sv | 49 ++++
 rtl/vx_issue_perf_ctr.sv | 101 ++++++++++
 tb/tb_vx_issue_perf_ctr.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU constants: execute-unit indices, SFU sub-types and the perf counter width.
package VX_gpu_pkg;

    localparam int EX_ALU = 0;
    localparam int EX_LSU = 1;
    localparam int EX_SFU = 2;
    localparam int EX_FPU = 3;

    localparam int SFU_WCTL = 0;
    localparam int SFU_CSRS = 1;

    localparam int PERF_CTR_BITS = 44;

    // Index widths never drop below one bit so single-entry tables still have a port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_perf_popcount_acc.sv
// Registered popcount-and-add counter: captures an event vector, then adds its
// population count to a free-running, wrapping counter.
module vx_perf_popcount_acc #(
    parameter int N        = 4,
    parameter int CTR_BITS = 44
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_in,
    input  logic [N-1:0]        ev_in,
    output logic [CTR_BITS-1:0] count_out
);

    localparam int INC_BITS = $clog2(N + 1);

    logic [N-1:0]        ev_p0_d, ev_p0_q;
    logic [CTR_BITS-1:0] cnt_p1_d, cnt_p1_q;

    function automatic logic [INC_BITS-1:0] popcount(input logic [N-1:0] v);
        logic [INC_BITS-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + INC_BITS'(v[k]);
        return c;
    endfunction

    // Clear drops both the sample being captured and the one already captured.
    always_comb begin
        ev_p0_d  = ev_in;
        cnt_p1_d = cnt_p1_q + CTR_BITS'(popcount(ev_p0_q));
        if (clear_in) begin
            ev_p0_d  = '0;
            cnt_p1_d = '0;
        end
    end

    // Stage 0 capture / stage 1 accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_p0_q  <= '0;
            cnt_p1_q <= '0;
        end else begin
            ev_p0_q  <= ev_p0_d;
            cnt_p1_q <= cnt_p1_d;
        end
    end

    assign count_out = cnt_p1_q;

endmodule

// File: rtl/vx_issue_perf_ctr.sv
// Issue-stage perf counters: ibuffer/scoreboard stall slice-cycles and dispatches per unit.
// Define PERF_SFU_CTR_EN to also build the per-SFU-sub-type dispatch counters.
module vx_issue_perf_ctr
    import VX_gpu_pkg::*;
#(
    parameter int  ISSUE_WIDTH   = 4,
    parameter int  NUM_EX_UNITS  = 4,
    parameter int  NUM_SFU_UNITS = 2,
    parameter int  SFU_EX_INDEX  = EX_SFU,
    parameter int  CTR_BITS      = PERF_CTR_BITS,
    localparam int EX_BITS       = clog2_min1(NUM_EX_UNITS),
    localparam int SFU_BITS      = clog2_min1(NUM_SFU_UNITS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clear_in,
    input  logic [ISSUE_WIDTH-1:0]                    ibf_stall_in,
    input  logic [ISSUE_WIDTH-1:0]                    scb_stall_in,
    input  logic [ISSUE_WIDTH-1:0]                    issue_fire_in,
    input  logic [ISSUE_WIDTH*EX_BITS-1:0]            issue_ex_type_in,
    input  logic [ISSUE_WIDTH*SFU_BITS-1:0]           issue_sfu_type_in,
    output logic [CTR_BITS-1:0]                       ibf_stalls,
    output logic [CTR_BITS-1:0]                       scb_stalls,
    output logic [NUM_EX_UNITS-1:0][CTR_BITS-1:0]     units_uses,
    output logic [NUM_SFU_UNITS-1:0][CTR_BITS-1:0]    sfu_uses
);

    logic [ISSUE_WIDTH-1:0][EX_BITS-1:0]      ex_type;
    logic [NUM_EX_UNITS-1:0][ISSUE_WIDTH-1:0] unit_ev;

    assign ex_type = issue_ex_type_in;

    // An ex type beyond the last unit matches no u, so it is dropped here.
    always_comb begin
        unit_ev = '0;
        for (int u = 0; u < NUM_EX_UNITS; u++) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                unit_ev[u][i] = issue_fire_in[i] && (ex_type[i] == EX_BITS'(u));
            end
        end
    end

    vx_perf_popcount_acc #(.N(ISSUE_WIDTH), .CTR_BITS(CTR_BITS)) u_ibf_acc (
        .clk       (clk),
        .reset     (reset),
        .clear_in  (clear_in),
        .ev_in     (ibf_stall_in),
        .count_out (ibf_stalls)
    );

    vx_perf_popcount_acc #(.N(ISSUE_WIDTH), .CTR_BITS(CTR_BITS)) u_scb_acc (
        .clk       (clk),
        .reset     (reset),
        .clear_in  (clear_in),
        .ev_in     (scb_stall_in),
        .count_out (scb_stalls)
    );

    for (genvar u = 0; u < NUM_EX_UNITS; u++) begin : g_unit
        vx_perf_popcount_acc #(.N(ISSUE_WIDTH), .CTR_BITS(CTR_BITS)) u_acc (
            .clk       (clk),
            .reset     (reset),
            .clear_in  (clear_in),
            .ev_in     (unit_ev[u]),
            .count_out (units_uses[u])
        );
    end

`ifdef PERF_SFU_CTR_EN
    logic [ISSUE_WIDTH-1:0][SFU_BITS-1:0]      sfu_type;
    logic [NUM_SFU_UNITS-1:0][ISSUE_WIDTH-1:0] sfu_ev;

    assign sfu_type = issue_sfu_type_in;

    always_comb begin
        sfu_ev = '0;
        for (int s = 0; s < NUM_SFU_UNITS; s++) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                sfu_ev[s][i] = issue_fire_in[i]
                            && (ex_type[i] == EX_BITS'(SFU_EX_INDEX))
                            && (sfu_type[i] == SFU_BITS'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_SFU_UNITS; s++) begin : g_sfu
        vx_perf_popcount_acc #(.N(ISSUE_WIDTH), .CTR_BITS(CTR_BITS)) u_acc (
            .clk       (clk),
            .reset     (reset),
            .clear_in  (clear_in),
            .ev_in     (sfu_ev[s]),
            .count_out (sfu_uses[s])
        );
    end
`else
    logic unused_sfu;
    assign unused_sfu = ^{issue_sfu_type_in, 1'(SFU_EX_INDEX)};
    assign sfu_uses   = '0;
`endif

endmodule

// File: tb/tb_vx_issue_perf_ctr.sv
// Self-checking bench for vx_issue_perf_ctr: a default instance plus a narrow
// (8-bit, 5-unit, 3-SFU) instance, checked against a counting model.
module tb_vx_issue_perf_ctr;

`ifdef PERF_SFU_CTR_EN
    localparam bit SFU_EN = 1'b1;
`else
    localparam bit SFU_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear_in;
    logic [3:0]  ibf, scb, fire0, fire1;
    logic [7:0]  ex0;
    logic [3:0]  sfu0;
    logic [11:0] ex1;
    logic [7:0]  sfu1;

    logic [43:0]       ibf0, scb0;
    logic [3:0][43:0]  units0;
    logic [1:0][43:0]  sfuu0;
    logic [7:0]        ibf1, scb1;
    logic [4:0][7:0]   units1;
    logic [2:0][7:0]   sfuu1;

    int checks = 0;
    int errors = 0;

    vx_issue_perf_ctr dut0 (
        .clk(clk), .reset(reset), .clear_in(clear_in),
        .ibf_stall_in(ibf), .scb_stall_in(scb), .issue_fire_in(fire0),
        .issue_ex_type_in(ex0), .issue_sfu_type_in(sfu0),
        .ibf_stalls(ibf0), .scb_stalls(scb0), .units_uses(units0), .sfu_uses(sfuu0)
    );

    vx_issue_perf_ctr #(.NUM_EX_UNITS(5), .NUM_SFU_UNITS(3), .CTR_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .clear_in(clear_in),
        .ibf_stall_in(ibf), .scb_stall_in(scb), .issue_fire_in(fire1),
        .issue_ex_type_in(ex1), .issue_sfu_type_in(sfu1),
        .ibf_stalls(ibf1), .scb_stalls(scb1), .units_uses(units1), .sfu_uses(sfuu1)
    );

    // Model: totals seen by the outputs, plus counts sampled but not yet visible.
    logic [43:0] m_ibf0, m_scb0, m_u0[4], m_s0[2];
    logic [7:0]  m_ibf1, m_scb1, m_u1[5], m_s1[3];
    int p_ibf, p_scb, p_u0[4], p_s0[2], p_u1[5], p_s1[3];

    task automatic model_zero();
        m_ibf0 = '0; m_scb0 = '0; m_ibf1 = '0; m_scb1 = '0;
        p_ibf = 0; p_scb = 0;
        foreach (m_u0[k]) begin m_u0[k] = '0; p_u0[k] = 0; end
        foreach (m_s0[k]) begin m_s0[k] = '0; p_s0[k] = 0; end
        foreach (m_u1[k]) begin m_u1[k] = '0; p_u1[k] = 0; end
        foreach (m_s1[k]) begin m_s1[k] = '0; p_s1[k] = 0; end
    endtask

    task automatic idle_inputs();
        clear_in = 1'b0; ibf = '0; scb = '0; fire0 = '0; fire1 = '0;
        ex0 = '0; sfu0 = '0; ex1 = '0; sfu1 = '0;
    endtask

    // One clock with the currently driven inputs; model updated at the edge.
    task automatic step();
        int n_ibf, n_scb, t, s;
        int n_u0[4], n_s0[2], n_u1[5], n_s1[3];
        bit rs, cl;
        rs = reset; cl = clear_in;
        n_ibf = $countones(ibf);
        n_scb = $countones(scb);
        foreach (n_u0[k]) n_u0[k] = 0;
        foreach (n_s0[k]) n_s0[k] = 0;
        foreach (n_u1[k]) n_u1[k] = 0;
        foreach (n_s1[k]) n_s1[k] = 0;
        for (int i = 0; i < 4; i++) begin
            if (fire0[i]) begin
                t = int'(ex0[i*2 +: 2]);
                s = int'(sfu0[i]);
                if (t < 4) n_u0[t]++;
                if (SFU_EN && t == 2 && s < 2) n_s0[s]++;
            end
            if (fire1[i]) begin
                t = int'(ex1[i*3 +: 3]);
                s = int'(sfu1[i*2 +: 2]);
                if (t < 5) n_u1[t]++;
                if (SFU_EN && t == 2 && s < 3) n_s1[s]++;
            end
        end
        @(posedge clk);
        if (rs || cl) begin
            model_zero();
        end else begin
            m_ibf0 = m_ibf0 + 44'(p_ibf); m_scb0 = m_scb0 + 44'(p_scb);
            m_ibf1 = m_ibf1 + 8'(p_ibf);  m_scb1 = m_scb1 + 8'(p_scb);
            foreach (m_u0[k]) m_u0[k] = m_u0[k] + 44'(p_u0[k]);
            foreach (m_s0[k]) m_s0[k] = m_s0[k] + 44'(p_s0[k]);
            foreach (m_u1[k]) m_u1[k] = m_u1[k] + 8'(p_u1[k]);
            foreach (m_s1[k]) m_s1[k] = m_s1[k] + 8'(p_s1[k]);
            p_ibf = n_ibf; p_scb = n_scb;
            p_u0 = n_u0; p_s0 = n_s0; p_u1 = n_u1; p_s1 = n_s1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_in = 1'b0;
        ibf = '1; scb = '1; fire0 = '1; fire1 = '1;
        ex0 = '1; sfu0 = '1; ex1 = '1; sfu1 = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({ibf0, scb0, units0, sfuu0} !== '0) begin
                errors++;
                $display("FAIL reset_hold0 cyc %0d got ibf=%0d scb=%0d units=%h sfu=%h want all 0", c, ibf0, scb0, units0, sfuu0);
            end
            checks++;
            if ({ibf1, scb1, units1, sfuu1} !== '0) begin
                errors++;
                $display("FAIL reset_hold1 cyc %0d got ibf=%0d scb=%0d units=%h sfu=%h want all 0", c, ibf1, scb1, units1, sfuu1);
            end
        end
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({ibf0, scb0, units0, sfuu0, ibf1, scb1, units1, sfuu1} !== '0) begin
                errors++;
                $display("FAIL reset_release cyc %0d got ibf0=%0d scb0=%0d units0=%h ibf1=%0d units1=%h want all 0", c, ibf0, scb0, units0, ibf1, units1);
            end
        end
    endtask

    task automatic test_stalls();
        ibf = 4'b1011; scb = 4'b0001;
        repeat (10) step();
        idle_inputs();
        repeat (2) step();
        checks++;
        if (ibf0 !== 44'd30) begin errors++; $display("FAIL stall_ibf0 got %0d want 30", ibf0); end
        checks++;
        if (scb0 !== 44'd10) begin errors++; $display("FAIL stall_scb0 got %0d want 10", scb0); end
        checks++;
        if (ibf1 !== 8'd30 || scb1 !== 8'd10) begin
            errors++; $display("FAIL stall_dut1 got ibf=%0d scb=%0d want 30/10", ibf1, scb1);
        end
    endtask

    task automatic test_units();
        logic [43:0] want_sfu;
        fire0 = 4'b1111; fire1 = 4'b1111;
        ex0 = {2'd2, 2'd2, 2'd1, 2'd0}; sfu0 = 4'b1000;
        ex1 = {3'd2, 3'd2, 3'd1, 3'd0}; sfu1 = {2'd1, 2'd0, 2'd0, 2'd0};
        repeat (5) step();
        idle_inputs();
        repeat (2) step();
        want_sfu = SFU_EN ? 44'd5 : 44'd0;
        checks++;
        if (units0 !== {44'd0, 44'd10, 44'd5, 44'd5}) begin
            errors++; $display("FAIL units0 got %0d,%0d,%0d,%0d want 5,5,10,0", units0[0], units0[1], units0[2], units0[3]);
        end
        checks++;
        if (sfuu0[0] !== want_sfu || sfuu0[1] !== want_sfu) begin
            errors++; $display("FAIL sfu0 got %0d,%0d want %0d,%0d", sfuu0[0], sfuu0[1], want_sfu, want_sfu);
        end
        checks++;
        if (units1 !== {8'd0, 8'd0, 8'd10, 8'd5, 8'd5}) begin
            errors++; $display("FAIL units1 got %h want 5,5,10,0,0", units1);
        end
        checks++;
        if (sfuu1 !== {8'd0, want_sfu[7:0], want_sfu[7:0]}) begin
            errors++; $display("FAIL sfu1 got %h want %0d,%0d,0", sfuu1, want_sfu, want_sfu);
        end
    endtask

    task automatic test_gating();
        logic [7:0] want_s1;
        ex0 = {4{2'd2}}; ex1 = {4{3'd2}};
        repeat (3) step();
        fire1 = 4'b1111; ex1 = {4{3'd7}}; sfu1 = '0;
        repeat (3) step();
        idle_inputs();
        repeat (2) step();
        checks++;
        if (units0 !== {44'd0, 44'd10, 44'd5, 44'd5}) begin
            errors++; $display("FAIL gate_units0 got %0d,%0d,%0d,%0d want 5,5,10,0", units0[0], units0[1], units0[2], units0[3]);
        end
        checks++;
        if (units1 !== {8'd0, 8'd0, 8'd10, 8'd5, 8'd5}) begin
            errors++; $display("FAIL gate_units1 got %h want 5,5,10,0,0", units1);
        end
        fire1 = 4'b1111; ex1 = {4{3'd2}}; sfu1 = {4{2'd3}};
        repeat (2) step();
        idle_inputs();
        repeat (2) step();
        want_s1 = SFU_EN ? 8'd5 : 8'd0;
        checks++;
        if (units1[2] !== 8'd18) begin errors++; $display("FAIL sfu_oob_unit got %0d want 18", units1[2]); end
        checks++;
        if (sfuu1 !== {8'd0, want_s1, want_s1}) begin
            errors++; $display("FAIL sfu_oob_sfu got %h want %0d,%0d,0", sfuu1, want_s1, want_s1);
        end
    endtask

    task automatic test_wrap();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0; ibf = 4'b0001;
        repeat (254) step();
        ibf = 4'b1111;
        step();
        idle_inputs();
        repeat (2) step();
        checks++;
        if (ibf1 !== 8'd2) begin errors++; $display("FAIL wrap_ibf1 got %0d want 2", ibf1); end
        checks++;
        if (ibf0 !== 44'd258) begin errors++; $display("FAIL wrap_ibf0 got %0d want 258", ibf0); end
    endtask

    task automatic test_clear();
        ibf = 4'b1111; clear_in = 1'b1;
        step();
        idle_inputs();
        repeat (2) step();
        checks++;
        if (ibf0 !== '0 || ibf1 !== '0) begin
            errors++; $display("FAIL clear_same got %0d/%0d want 0", ibf0, ibf1);
        end
        ibf = 4'b1111;
        step();
        ibf = '0; clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        repeat (2) step();
        checks++;
        if (ibf0 !== '0 || ibf1 !== '0) begin
            errors++; $display("FAIL clear_next got %0d/%0d want 0", ibf0, ibf1);
        end
        clear_in = 1'b1;
        step();
        clear_in = 1'b0; ibf = 4'b1111;
        step();
        ibf = '0;
        checks++;
        if (ibf0 !== '0) begin errors++; $display("FAIL clear_after_lat got %0d want 0", ibf0); end
        step();
        checks++;
        if (ibf0 !== 44'd4 || ibf1 !== 8'd4) begin
            errors++; $display("FAIL clear_after got %0d/%0d want 4", ibf0, ibf1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_in = ($urandom_range(0, 39) == 0);
            ibf = 4'($urandom); scb = 4'($urandom);
            fire0 = 4'($urandom); fire1 = 4'($urandom);
            ex0 = 8'($urandom); sfu0 = 4'($urandom);
            ex1 = 12'($urandom); sfu1 = 8'($urandom);
            step();
            checks++;
            if (ibf0 !== m_ibf0 || scb0 !== m_scb0) begin
                errors++; $display("FAIL rnd_stall0 cyc %0d got %0d/%0d want %0d/%0d", c, ibf0, scb0, m_ibf0, m_scb0);
            end
            checks++;
            if (ibf1 !== m_ibf1 || scb1 !== m_scb1) begin
                errors++; $display("FAIL rnd_stall1 cyc %0d got %0d/%0d want %0d/%0d", c, ibf1, scb1, m_ibf1, m_scb1);
            end
            for (int u = 0; u < 4; u++) begin
                checks++;
                if (units0[u] !== m_u0[u]) begin errors++; $display("FAIL rnd_units0[%0d] cyc %0d got %0d want %0d", u, c, units0[u], m_u0[u]); end
            end
            for (int u = 0; u < 5; u++) begin
                checks++;
                if (units1[u] !== m_u1[u]) begin errors++; $display("FAIL rnd_units1[%0d] cyc %0d got %0d want %0d", u, c, units1[u], m_u1[u]); end
            end
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (sfuu0[s] !== m_s0[s]) begin errors++; $display("FAIL rnd_sfu0[%0d] cyc %0d got %0d want %0d", s, c, sfuu0[s], m_s0[s]); end
            end
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (sfuu1[s] !== m_s1[s]) begin errors++; $display("FAIL rnd_sfu1[%0d] cyc %0d got %0d want %0d", s, c, sfuu1[s], m_s1[s]); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_zero();
        test_reset();
        test_stalls();
        test_units();
        test_gating();
        test_wrap();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
